// File: rtl/max_hit_pkg.sv
// Shared types and default constants for the max-hit window checker.
package max_hit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_MAX_VALUE = 15;
  localparam int unsigned DEF_MIN_HITS  = 1;
  localparam int unsigned DEF_MAX_HITS  = 5;
  localparam int unsigned DEF_WINDOW    = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that saturates at SAT; exposes its next value.
module sat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned SAT   = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_next
);

  localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT);

  logic [WIDTH-1:0] r_count;

  always_comb begin
    o_count_next = r_count;
    if (i_clear)
      o_count_next = '0;
    else if (i_inc && (r_count != SAT_V))
      o_count_next = r_count + WIDTH'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_count <= '0;
    else
      r_count <= o_count_next;
  end

  assign o_count = r_count;

endmodule

// File: rtl/max_hit_window_checker.sv
// Opens a window of WINDOW cycles, tallies cycles where the count equals MAX_VALUE,
// and reports pass when the tally lands within [MIN_HITS, MAX_HITS].
module max_hit_window_checker
  import max_hit_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MAX_VALUE = WIDTH'(DEF_MAX_VALUE),
  parameter int unsigned      MIN_HITS  = DEF_MIN_HITS,
  parameter int unsigned      MAX_HITS  = DEF_MAX_HITS,
  parameter int unsigned      WINDOW    = DEF_WINDOW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WIDTH-1:0]              count_in,
  input  logic                          count_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(MAX_HITS+2)-1:0] hits
);

  localparam int unsigned HW = $clog2(MAX_HITS + 2);
  localparam int unsigned CW = $clog2(WINDOW);
  localparam logic [HW-1:0] MIN_H = HW'(MIN_HITS);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HITS);
  localparam logic [CW-1:0] LAST  = CW'(WINDOW - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cycle;
  logic            r_pass;
  logic            w_hit;
  logic            w_clear;
  logic            w_inc;
  logic            w_report;
  logic            w_verdict;
  logic [HW-1:0]   w_hits;
  logic [HW-1:0]   w_hits_next;

  assign w_hit = count_valid && (count_in == MAX_VALUE);

  sat_counter #(
    .WIDTH (HW),
    .SAT   (MAX_HITS + 1)
  ) u_hit_tally (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_clear      (w_clear),
    .i_inc        (w_inc),
    .o_count      (w_hits),
    .o_count_next (w_hits_next)
  );

  // Verdict uses the post-increment tally so a hit on the final or overflowing cycle is included.
  assign w_verdict = (w_hits_next >= MIN_H) && (w_hits_next <= MAX_H);

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_inc        = 1'b0;
    w_report     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_clear      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
        end else begin
          w_inc = w_hit;
          if ((w_hit && (w_hits == MAX_H)) || (r_cycle == LAST)) begin
            w_state_next = REPORT;
            w_report     = 1'b1;
          end
        end
      end
      REPORT: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cycle <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear)
        r_cycle <= '0;
      else if ((r_state == RUN) && (w_state_next == RUN))
        r_cycle <= r_cycle + CW'(1);
      if (w_report)
        r_pass <= w_verdict;
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == REPORT);
  assign pass = r_pass;
  assign hits = w_hits;

endmodule

// File: tb/tb_max_hit_window_checker.sv
// Directed self-checking bench for max_hit_window_checker with a 16-cycle window.
module tb_max_hit_window_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] count_in;
  logic       count_valid;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] hits;

  int total;
  int bad;

  max_hit_window_checker #(
    .WIDTH     (4),
    .MAX_VALUE (4'hF),
    .MIN_HITS  (1),
    .MAX_HITS  (5),
    .WINDOW    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .count_in    (count_in),
    .count_valid (count_valid),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .hits        (hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] c);
    count_valid = v;
    count_in    = c;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; abort = 1'b1; count_valid = 1'b1; count_in = 4'hF;
    tick(); tick();
    total++;
    if ({busy, done, pass, hits} !== 6'b0) begin
      bad++; $display("FAIL reset_state: got busy=%b done=%b pass=%b hits=%0d want all 0", busy, done, pass, hits);
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; count_valid = 1'b0; count_in = 4'h0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_free_count();
    do_start();
    total++;
    if (busy !== 1'b1 || hits !== 3'd0) begin
      bad++; $display("FAIL free_start: got busy=%b hits=%0d want busy=1 hits=0", busy, hits);
    end
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 4'(k));
      if (k < 15) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++; $display("FAIL free_run_c%0d: got busy=%b done=%b want busy=1 done=0", k, busy, done);
        end
      end
    end
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || hits !== 3'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL free_report: got done=%b pass=%b hits=%0d busy=%b want 1 1 1 0", done, pass, hits, busy);
    end
    drive(1'b0, 4'h0);
    total++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      bad++; $display("FAIL free_done_once: got done=%b pass=%b want done=0 pass=1", done, pass);
    end
  endtask

  task automatic test_no_hit();
    do_start();
    for (int k = 0; k < 16; k++) drive(1'b1, 4'hE);
    total++;
    if (done !== 1'b1 || pass !== 1'b0 || hits !== 3'd0) begin
      bad++; $display("FAIL no_hit: got done=%b pass=%b hits=%0d want 1 0 0", done, pass, hits);
    end
    tick();
  endtask

  task automatic test_last_cycle_hit();
    do_start();
    for (int k = 0; k < 15; k++) drive(1'b1, 4'h0);
    drive(1'b1, 4'hF);
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || hits !== 3'd1) begin
      bad++; $display("FAIL last_hit_valid: got done=%b pass=%b hits=%0d want 1 1 1", done, pass, hits);
    end
    tick();
    do_start();
    for (int k = 0; k < 15; k++) drive(1'b1, 4'h0);
    drive(1'b0, 4'hF);
    total++;
    if (done !== 1'b1 || pass !== 1'b0 || hits !== 3'd0) begin
      bad++; $display("FAIL last_hit_invalid: got done=%b pass=%b hits=%0d want 1 0 0", done, pass, hits);
    end
    tick();
  endtask

  task automatic test_early_fail();
    do_start();
    for (int k = 0; k < 10; k++) drive(1'b1, (k % 2 == 0) ? 4'hF : 4'h3);
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || hits !== 3'd5) begin
      bad++; $display("FAIL early_pre: got busy=%b done=%b hits=%0d want 1 0 5", busy, done, hits);
    end
    drive(1'b1, 4'hF);
    total++;
    if (done !== 1'b1 || pass !== 1'b0 || hits !== 3'd6 || busy !== 1'b0) begin
      bad++; $display("FAIL early_fail: got done=%b pass=%b hits=%0d busy=%b want 1 0 6 0", done, pass, hits, busy);
    end
    drive(1'b0, 4'h0);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL early_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_max_boundary();
    do_start();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, (k >= 3 && k <= 7) ? 4'hF : 4'h1);
      if (k == 7) begin
        total++;
        if (busy !== 1'b1 || hits !== 3'd5) begin
          bad++; $display("FAIL max_contig: got busy=%b hits=%0d want 1 5", busy, hits);
        end
      end
    end
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || hits !== 3'd5) begin
      bad++; $display("FAIL max_boundary: got done=%b pass=%b hits=%0d want 1 1 5", done, pass, hits);
    end
    tick();
  endtask

  task automatic test_abort();
    do_start();
    for (int k = 0; k < 7; k++) drive(1'b1, (k < 5) ? 4'hF : 4'h2);
    abort = 1'b1;
    drive(1'b1, 4'hF);
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || hits !== 3'd5 || pass !== 1'b1) begin
      bad++; $display("FAIL abort_hit: got busy=%b done=%b hits=%0d pass=%b want 0 0 5 1", busy, done, hits, pass);
    end
    do_start();
    total++;
    if (busy !== 1'b1 || hits !== 3'd0) begin
      bad++; $display("FAIL abort_restart: got busy=%b hits=%0d want 1 0", busy, hits);
    end
    abort = 1'b1;
    drive(1'b0, 4'h0);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL abort_ignored_idle: got busy=%b want 1", busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_start();
    for (int k = 0; k < 5; k++) drive(1'b1, (k == 1) ? 4'hF : 4'h0);
    reset = 1'b0;
    drive(1'b1, 4'hF);
    reset = 1'b1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || hits !== 3'd0) begin
      bad++; $display("FAIL reset_mid_run: got busy=%b done=%b pass=%b hits=%0d want 0 0 0 0", busy, done, pass, hits);
    end
  endtask

  task automatic test_start_in_report();
    do_start();
    for (int k = 0; k < 16; k++) drive(1'b1, 4'hE);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL report_reached: got done=%b want 1", done);
    end
    start = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL start_in_report: got busy=%b done=%b want 0 0", busy, done);
    end
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL start_after_report: got busy=%b want 1", busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; count_in = 4'h0; count_valid = 1'b0;
    test_reset();
    test_free_count();
    test_no_hit();
    test_last_cycle_hit();
    test_early_fail();
    test_max_boundary();
    test_abort();
    test_reset_mid_run();
    test_start_in_report();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
